// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Two-entry skid buffer sitting between the instruction source and the ALU
// decoder/datapath. Entries are {op, a, b}. The main register always drives
// out_*; the skid register absorbs one extra entry so that in_ready can be a
// pure register output (no combinational path from out_ready to in_ready).
//
// Ports
//   clk        rising-edge clock, sole clock domain
//   rst_n      synchronous active-low reset
//   flush      synchronous discard of all buffered entries
//   in_valid   upstream entry present
//   in_ready   stage can accept an entry this cycle (registered)
//   in_op      3-bit ALU opcode, passed through unmodified
//   in_a/in_b  WIDTH-bit operands
//   out_valid  entry presented to the ALU
//   out_ready  downstream consumes the entry
//   out_op     opcode into the decoder
//   out_a/b    operands into the datapath
//   issue_cnt  16-bit saturating issued-entry count (only with the macro)
//
// Build option
//   ALU_ISSUE_CNT_EN  when defined, adds the issue_cnt port and its counter.
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef ALU_ISSUE_CNT_EN
    output logic [15:0]      issue_cnt,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_op,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b
);

    // Occupancy states
    localparam logic [1:0] S_EMPTY = 2'd0;  // no entries
    localparam logic [1:0] S_ONE   = 2'd1;  // main full
    localparam logic [1:0] S_FULL  = 2'd2;  // main and skid full

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    logic [1:0] state_q, state_d;
    entry_t     main_q,  main_d;
    entry_t     skid_q,  skid_d;
    logic       in_ready_q, in_ready_d;

    entry_t     in_ent;
    logic       accept;
    logic       pop;

    assign in_ent = '{op: in_op, a: in_a, b: in_b};

    // Both handshakes are qualified only by registered state, so nothing on
    // the output side depends combinationally on in_* or out_ready.
    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = in_ready_q;
    assign out_op    = main_q.op;
    assign out_a     = main_q.a;
    assign out_b     = main_q.b;

    assign accept = in_valid  & in_ready_q;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Flush beats any concurrent accept or pop; data regs keep stale
            // contents, which are don't-care while out_valid is low.
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_d  = in_ent;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    case ({accept, pop})
                        2'b10: begin
                            skid_d  = in_ent;
                            state_d = S_FULL;
                        end
                        2'b01: state_d = S_EMPTY;
                        2'b11: main_d = in_ent;  // replace popped head in place
                        default: ;
                    endcase
                end
                S_FULL: begin
                    // in_ready_q is low here, so accept cannot occur.
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end

        // Ready for next cycle is simply "not going to be full".
        in_ready_d = (state_d != S_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef ALU_ISSUE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts real issues only: a pop cancelled by flush does not count,
    // but flush never clears the count.
    always_comb begin
        cnt_d = cnt_q;
        if (pop && !flush && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign issue_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]       in_op, out_op;
    logic [WIDTH-1:0] in_a, in_b, out_a, out_b;
`ifdef ALU_ISSUE_CNT_EN
    logic [15:0]      issue_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    alu_issue_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
`ifdef ALU_ISSUE_CNT_EN
        .issue_cnt(issue_cnt),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_a(out_a), .out_b(out_b)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        in_valid = v; in_op = op; in_a = a; in_b = b;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        #2;
        tick(); tick();

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_out_a", 32'(out_a), 32'd0);
        chk("rst_out_b", 32'(out_b), 32'd0);
`ifdef ALU_ISSUE_CNT_EN
        chk("rst_cnt", 32'(issue_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Single entry, one-cycle latency, popped next edge
        drive(1'b1, 3'b001, 8'h12, 8'h34); out_ready = 1'b1;
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_op", 32'(out_op), 32'd1);
        chk("single_a", 32'(out_a), 32'h12);
        chk("single_b", 32'(out_b), 32'h34);
        tick();
        chk("single_popped", 32'(out_valid), 32'd0);

        // Back-to-back fill with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 8'h01, 8'h02);
        tick();
        chk("fill1_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 3'b010, 8'h03, 8'h04);
        tick();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_op", 32'(out_op), 32'd0);
        drive(1'b1, 3'b011, 8'h05, 8'h06);
        tick();
        chk("hold_op", 32'(out_op), 32'd0);
        chk("hold_a", 32'(out_a), 32'h01);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);

        // FULL with pop and in_valid together: pop only
        out_ready = 1'b1;
        tick();
        chk("full_pop_op", 32'(out_op), 32'd2);
        chk("full_pop_a", 32'(out_a), 32'h03);
        chk("full_pop_in_ready", 32'(in_ready), 32'd1);
        tick();  // held op 011 accepted while 010 pops
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        chk("order3_op", 32'(out_op), 32'd3);
        chk("order3_b", 32'(out_b), 32'h06);
        chk("order3_valid", 32'(out_valid), 32'd1);
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
`ifdef ALU_ISSUE_CNT_EN
        chk("cnt_after_drain", 32'(issue_cnt), 32'd4);
`endif

        // Flush from FULL dominates accept and pop
        out_ready = 1'b0;
        drive(1'b1, 3'b100, 8'h11, 8'h22); tick();
        drive(1'b1, 3'b101, 8'h33, 8'h44); tick();
        chk("pre_flush_full", 32'(in_ready), 32'd0);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_ISSUE_CNT_EN
        chk("flush_cnt", 32'(issue_cnt), 32'd4);
`endif
        tick();
        chk("flush_stays_empty", 32'(out_valid), 32'd0);

        // Reset mid-operation discards a pending entry
        out_ready = 1'b0;
        drive(1'b1, 3'b110, 8'hAA, 8'h55);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        chk("pend_op", 32'(out_op), 32'd6);
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_op", 32'(out_op), 32'd0);
        chk("midrst_a", 32'(out_a), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
`ifdef ALU_ISSUE_CNT_EN
        chk("midrst_cnt", 32'(issue_cnt), 32'd0);
`endif
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_valid", 32'(out_valid), 32'd0);

        // All eight opcodes streamed through unchanged
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 8'(i * 3), 8'(8'hF0 ^ i));
            tick();
            chk("op_pass", 32'(out_op), 32'(i));
            chk("op_pass_a", 32'(out_a), 32'(i * 3));
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        chk("stream_drain", 32'(out_valid), 32'd0);
`ifdef ALU_ISSUE_CNT_EN
        chk("stream_cnt", 32'(issue_cnt), 32'd8);

        // Saturation: streaming k ticks from EMPTY gives k-1 pops
        drive(1'b1, 3'b111, 8'h00, 8'h00);
        repeat (65527) tick();
        chk("cnt_fffe", 32'(issue_cnt), 32'h0000FFFE);
        tick();
        chk("cnt_ffff", 32'(issue_cnt), 32'h0000FFFF);
        repeat (3) tick();
        chk("cnt_sat", 32'(issue_cnt), 32'h0000FFFF);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        chk("cnt_sat_drain", 32'(issue_cnt), 32'h0000FFFF);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 flush  input  1  synchronous discard of all buffered entries.
REQ-005 in_valid  input  1  upstream entry present.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_op  input  3  ALU opcode, same 3-bit encoding the ALU decoder consumes.
REQ-008 in_a, in_b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  entry presented to ALU decoder/datapath.
REQ-010 out_ready  input  1  downstream consumes entry.
REQ-011 out_op  output  3  opcode, driven straight into the decoder op input.
REQ-012 out_a, out_b  output  WIDTH each  operands for the ALU datapath.
REQ-013 issue_cnt  output  16  issued-entry count (present only with ALU_ISSUE_CNT_EN).

Function
REQ-014 Entry = {op, a, b}; transfer occurs on a rising edge where valid and ready are both high.
REQ-015 Two-entry skid buffer: main register (drives out_*) plus skid register.
REQ-016 State machine, states EMPTY (0 entries), ONE (main full), FULL (main and skid full).
REQ-017 EMPTY: in accept -> ONE, entry to main.
REQ-018 ONE: accept without pop -> FULL, entry to skid; pop without accept -> EMPTY; accept and pop -> ONE, new entry to main.
REQ-019 FULL: pop -> ONE, skid moves to main; no accept possible.
REQ-020 in_ready shall be a registered signal, high in EMPTY and ONE, low in FULL and in the cycle rst_n is low.
REQ-021 out_valid shall be high exactly in ONE and FULL; out_* shall come only from main register.
REQ-022 Latency: entry accepted at edge N appears on out_* after edge N when stage was EMPTY; no combinational path from in_* or out_ready to any output.
REQ-023 out_op/out_a/out_b shall hold stable while out_valid is high and out_ready is low.
REQ-024 Order preserved: entries leave in exactly the order accepted; none duplicated or lost except by flush/reset.
REQ-025 flush high: next state EMPTY, any concurrent accept or pop ignored (not counted), flush dominates both.
REQ-026 All 8 opcode values pass through unmodified; stage does no opcode decoding.
REQ-027 Data registers need not be cleared on pop; out_* value when out_valid is low is don't-care except after reset.

Reset
REQ-028 rst_n low at a clock edge: state EMPTY, out_valid 0, in_ready 0 during reset, out_op 3'b000, out_a and out_b zero, issue_cnt 0.
REQ-029 Reset mid-operation discards all buffered entries; in_ready rises to 1 the first edge after rst_n returns high.

Configuration
REQ-030 Macro ALU_ISSUE_CNT_EN defined: issue_cnt increments by 1 on each out_valid&&out_ready edge, saturates at 16'hFFFF, unaffected by flush, cleared only by reset.
REQ-031 Macro ALU_ISSUE_CNT_EN undefined: issue_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-032 Reset, then in_valid=1, op=3'b001, a=8'h12, b=8'h34, out_ready=1 -> out_valid=1 next cycle with op 001, a 12, b 34; popped the same edge.
REQ-033 out_ready=0, push op 000, 010, 011 back-to-back -> first two accepted (FULL), in_ready=0 on third, third held upstream; then out_ready=1 -> outputs 000, 010, 011 in order.
REQ-034 FULL, out_ready=1 and in_valid=1 same cycle -> pop only, state ONE, in_ready=1 next cycle, no entry lost.
REQ-035 FULL, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, state EMPTY, issue_cnt unchanged.
REQ-036 ONE with op 3'b110 pending, rst_n=0 one cycle -> out_valid=0, out_op 000, issue_cnt 0; entry never issued.
REQ-037 ALU_ISSUE_CNT_EN defined, counter preset near max by 65535 pops, then 3 more pops -> issue_cnt holds 16'hFFFF.
